// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, FSM state types and the baud divider helper
//               for the 8N1 UART core.
// Macro       : UART_FRAMING_CHECK_EN adds the RX_WAIT_HIGH receiver state.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

   localparam int DATA_BITS  = 8;
   localparam int OVERSAMPLE = 16;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3
`ifdef UART_FRAMING_CHECK_EN
      , RX_WAIT_HIGH = 3'd4
`endif
   } rx_state_t;

   // Oversampling tick divider, truncated, never below 1.
   function automatic int calc_div(input int freq_hz, input int baud);
      int d;
      d = freq_hz / (baud * OVERSAMPLE);
      return (d < 1) ? 1 : d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Free-running 1-cycle tick strobe, one pulse every DIV clocks.
// Ports       : clk   - system clock
//               reset - asynchronous, active-low
//               tick  - 1-cycle strobe
// Revision    : 1.0  initial release
// ============================================================================
module uart_baud_gen #(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int c_CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [c_CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         tick  <= 1'b0;
      end else if (r_cnt == c_CW'(DIV - 1)) begin
         r_cnt <= '0;
         tick  <= 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
         tick  <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_core
// Description : 8N1 full-duplex UART. RX runs on a 16x oversampling tick,
//               TX uses an exact 16*DIV clock per-bit counter.
// Ports       : clk, reset (async active-low)
//               uart_rxd / uart_txd      - serial pins, idle high
//               rx_data, rx_avail, rx_error, rx_ack - receive handshake
//               tx_data, tx_wr, tx_busy  - transmit handshake
// Macro       : UART_FRAMING_CHECK_EN - enables stop-bit checking, rx_error
//               and the wait-for-line-high state after a framing error.
// Revision    : 1.0  initial release
// ============================================================================
module uart_core
   import uart_pkg::*;
#(
   parameter int freq_hz = 50000000,
   parameter int baud    = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rxd,
   output logic       uart_txd,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   output logic       rx_error,
   input  logic       rx_ack,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_busy
);

   localparam int c_DIV        = calc_div(freq_hz, baud);
   localparam int c_BIT_CYCLES = OVERSAMPLE * c_DIV;
   localparam int c_TXW        = $clog2(c_BIT_CYCLES);

   // ------------------------------------------------------------------ TX
   tx_state_t        r_tx_state;
   logic [c_TXW-1:0] r_tx_cnt;
   logic [2:0]       r_tx_bit;
   logic [7:0]       r_tx_shift;
   logic             w_tx_bit_end;

   assign w_tx_bit_end = (r_tx_cnt == c_TXW'(c_BIT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         uart_txd   <= 1'b1;
         tx_busy    <= 1'b0;
      end else begin
         if (r_tx_state != TX_IDLE)
            r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
         case (r_tx_state)
            TX_IDLE: if (tx_wr) begin
               r_tx_shift <= tx_data;
               r_tx_cnt   <= '0;
               r_tx_bit   <= '0;
               uart_txd   <= 1'b0;
               tx_busy    <= 1'b1;
               r_tx_state <= TX_START;
            end
            TX_START: if (w_tx_bit_end) begin
               uart_txd   <= r_tx_shift[0];
               r_tx_shift <= {1'b0, r_tx_shift[7:1]};
               r_tx_state <= TX_DATA;
            end
            TX_DATA: if (w_tx_bit_end) begin
               if (r_tx_bit == 3'(DATA_BITS - 1)) begin
                  uart_txd   <= 1'b1;
                  r_tx_state <= TX_STOP;
               end else begin
                  uart_txd   <= r_tx_shift[0];
                  r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  r_tx_bit   <= r_tx_bit + 1'b1;
               end
            end
            TX_STOP: if (w_tx_bit_end) begin
               tx_busy    <= 1'b0;
               r_tx_state <= TX_IDLE;
            end
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------ RX
   logic       w_tick;
   rx_state_t  r_rx_state;
   logic       r_rx_meta;
   logic       r_rx_sync;
   logic [3:0] r_rx_cnt;
   logic [2:0] r_rx_bit;
   logic [7:0] r_rx_shift;
   logic       w_rx_half;
   logic       w_rx_full;

   uart_baud_gen #(.DIV(c_DIV)) u_baud_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (w_tick)
   );

   assign w_rx_half = (r_rx_cnt == 4'(OVERSAMPLE / 2 - 1));
   assign w_rx_full = (r_rx_cnt == 4'(OVERSAMPLE - 1));

`ifndef UART_FRAMING_CHECK_EN
   assign rx_error = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_state <= RX_IDLE;
         r_rx_meta  <= 1'b1;        // synchronizer idles at line-idle level
         r_rx_sync  <= 1'b1;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         rx_data    <= '0;
         rx_avail   <= 1'b0;
`ifdef UART_FRAMING_CHECK_EN
         rx_error   <= 1'b0;
`endif
      end else begin
         r_rx_meta <= uart_rxd;
         r_rx_sync <= r_rx_meta;

         // Ack clears first so a completion in the same cycle overrides it.
         if (rx_ack) begin
            rx_avail <= 1'b0;
`ifdef UART_FRAMING_CHECK_EN
            rx_error <= 1'b0;
`endif
         end

         case (r_rx_state)
            RX_IDLE: if (w_tick && !r_rx_sync) begin
               r_rx_cnt   <= '0;
               r_rx_state <= RX_START;
            end
            RX_START: if (w_tick) begin
               if (w_rx_half) begin
                  r_rx_cnt <= '0;
                  r_rx_bit <= '0;
                  // Line back high at mid start bit: treat as a glitch.
                  r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            RX_DATA: if (w_tick) begin
               if (w_rx_full) begin
                  r_rx_cnt   <= '0;
                  r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                  if (r_rx_bit == 3'(DATA_BITS - 1))
                     r_rx_state <= RX_STOP;
                  else
                     r_rx_bit <= r_rx_bit + 1'b1;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            RX_STOP: if (w_tick) begin
               if (w_rx_full) begin
                  r_rx_cnt <= '0;
`ifdef UART_FRAMING_CHECK_EN
                  if (r_rx_sync) begin
                     rx_data    <= r_rx_shift;
                     rx_avail   <= 1'b1;
                     r_rx_state <= RX_IDLE;
                  end else begin
                     rx_error   <= 1'b1;
                     r_rx_state <= RX_WAIT_HIGH;
                  end
`else
                  rx_data    <= r_rx_shift;
                  rx_avail   <= 1'b1;
                  r_rx_state <= RX_IDLE;
`endif
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
`ifdef UART_FRAMING_CHECK_EN
            // Hold off until the broken frame releases the line.
            RX_WAIT_HIGH: if (r_rx_sync) r_rx_state <= RX_IDLE;
`endif
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_core
// Description : Self-checking bench for uart_core. A timestamp-based model
//               predicts uart_txd/tx_busy every cycle; receive results are
//               checked against bench-side expected bytes and flags.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_core;

   localparam int BIT = 432;   // 16 * (50e6 / (115200*16)) = 16 * 27

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_ack = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_wr = 1'b0;
   logic       loop = 1'b0;
   logic       rxd_drv = 1'b1;
   logic       w_rxd;
   logic       uart_txd;
   logic [7:0] rx_data;
   logic       rx_avail;
   logic       rx_error;
   logic       tx_busy;

   assign w_rxd = loop ? uart_txd : rxd_drv;

   uart_core #(.freq_hz(50000000), .baud(115200)) dut (
      .clk      (clk),
      .reset    (reset),
      .uart_rxd (w_rxd),
      .uart_txd (uart_txd),
      .rx_data  (rx_data),
      .rx_avail (rx_avail),
      .rx_error (rx_error),
      .rx_ack   (rx_ack),
      .tx_data  (tx_data),
      .tx_wr    (tx_wr),
      .tx_busy  (tx_busy)
   );

   always #10 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- TX model
   // A frame is a 10-bit sequence; bit k/BIT of the frame is on the line k
   // cycles after the accepting edge, for exactly 10*BIT cycles.
   int         cyc = 0;
   int         m_acc = 0;
   logic       m_active = 1'b0;
   logic [7:0] m_byte = 8'h00;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset) begin
         m_active <= 1'b0;
      end else if (!m_active && tx_wr) begin
         m_active <= 1'b1;
         m_acc    <= cyc + 1;
         m_byte   <= tx_data;
      end else if (m_active && (cyc + 1 - m_acc) >= 10 * BIT) begin
         m_active <= 1'b0;
      end
   end

   logic e_txd, e_busy;
   int   e_k;

   always @(negedge clk) begin
      if (!reset) begin
         e_txd  = 1'b1;
         e_busy = 1'b0;
         chk("rst_rx_avail", rx_avail, 0);
         chk("rst_rx_error", rx_error, 0);
         chk("rst_rx_data", rx_data, 0);
      end else if (m_active) begin
         e_k    = cyc - m_acc;
         e_busy = 1'b1;
         if (e_k < BIT)          e_txd = 1'b0;
         else if (e_k < 9 * BIT) e_txd = m_byte[e_k / BIT - 1];
         else                    e_txd = 1'b1;
      end else begin
         e_txd  = 1'b1;
         e_busy = 1'b0;
      end
      chk("txd", uart_txd, e_txd);
      chk("tx_busy", tx_busy, e_busy);
`ifndef UART_FRAMING_CHECK_EN
      chk("rx_error_tied", rx_error, 0);
`endif
   end

   // ---------------------------------------------------------------- helpers
   task automatic pulse_tx(input logic [7:0] b);
      tx_data = b;
      tx_wr   = 1'b1;
      @(negedge clk);
      tx_wr   = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (tx_busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("tx_idle_timeout", tx_busy, 0);
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      chk("ack_clears_avail", rx_avail, 0);
      chk("ack_clears_error", rx_error, 0);
   endtask

   task automatic send_serial(input logic [7:0] b, input logic stop);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd_drv = frame[i];
         repeat (BIT) @(negedge clk);
      end
      rxd_drv = 1'b1;
   endtask

   // ---------------------------------------------------------------- main
   int         busy_cnt;
   int         exp_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
   logic [7:0] prev_rx;
   logic [7:0] rb, prev_b;

   initial begin
      // Reset
      repeat (4) @(negedge clk);
      chk("reset_txd", uart_txd, 1);
      chk("reset_busy", tx_busy, 0);
      chk("reset_avail", rx_avail, 0);
      chk("reset_error", rx_error, 0);
      chk("reset_data", rx_data, 8'h00);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // TX frame A5 with an ignored second write
      tx_data = 8'hA5;
      tx_wr   = 1'b1;
      @(negedge clk);
      busy_cnt = 0;
      for (int i = 0; i < 4400; i++) begin
         if (i == 0)   tx_wr = 1'b0;
         if (i == 100) begin tx_data = 8'hFF; tx_wr = 1'b1; end
         if (i == 101) tx_wr = 1'b0;
         if (tx_busy) busy_cnt++;
         if ((i % BIT) == BIT / 2 && i < 10 * BIT)
            chk($sformatf("a5_bit%0d", i / BIT), uart_txd, exp_bits[i / BIT]);
         @(negedge clk);
      end
      chk("a5_busy_cycles", busy_cnt, 4320);

      // Loopback 3C
      loop = 1'b1;
      pulse_tx(8'h3C);
      wait_idle(10 * BIT + 10);
      chk("loop_avail", rx_avail, 1);
      chk("loop_data", rx_data, 8'h3C);
      do_ack();
      loop = 1'b0;
      repeat (20) @(negedge clk);

      // Framing error: 55 with stop bit low
      prev_rx = rx_data;
      send_serial(8'h55, 1'b0);
`ifdef UART_FRAMING_CHECK_EN
      chk("frame_error", rx_error, 1);
      chk("frame_avail", rx_avail, 0);
      chk("frame_data_kept", rx_data, prev_rx);
`else
      chk("frame_avail", rx_avail, 1);
      chk("frame_data", rx_data, 8'h55);
      chk("frame_error", rx_error, 0);
`endif
      repeat (BIT) @(negedge clk);
      do_ack();

      // Glitch then a valid 81 frame
      rxd_drv = 1'b0;
      repeat (200) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      chk("glitch_no_avail", rx_avail, 0);
      send_serial(8'h81, 1'b1);
      chk("after_glitch_avail", rx_avail, 1);
      chk("after_glitch_data", rx_data, 8'h81);
      do_ack();

      // Random back-to-back loopback frames
      loop = 1'b1;
      prev_b = 8'h00;
      for (int k = 0; k < 4; k++) begin
         rb = 8'($urandom_range(0, 255));
         wait_idle(10 * BIT + 10);
         if (k > 0) begin
            chk("rand_avail", rx_avail, 1);
            chk("rand_data", rx_data, prev_b);
            rx_ack = 1'b1;
         end
         tx_data = rb;
         tx_wr   = 1'b1;
         @(negedge clk);
         tx_wr  = 1'b0;
         rx_ack = 1'b0;
         if (k > 0) chk("rand_ack", rx_avail, 0);
         prev_b = rb;
      end
      wait_idle(10 * BIT + 10);
      chk("rand_last_avail", rx_avail, 1);
      chk("rand_last_data", rx_data, prev_b);
      do_ack();
      loop = 1'b0;
      repeat (20) @(negedge clk);

      // Overrun: 11 then 22 without ack
      send_serial(8'h11, 1'b1);
      send_serial(8'h22, 1'b1);
      chk("overrun_avail", rx_avail, 1);
      chk("overrun_data", rx_data, 8'h22);

      // Reset in the middle of a looped-back frame
      loop = 1'b1;
      pulse_tx(8'h77);
      repeat (5 * BIT) @(negedge clk);
      #3 reset = 1'b0;
      @(negedge clk);
      chk("midrst_avail", rx_avail, 0);
      chk("midrst_txd", uart_txd, 1);
      chk("midrst_busy", tx_busy, 0);
      chk("midrst_data", rx_data, 8'h00);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (12 * BIT) @(negedge clk);
      chk("midrst_no_partial", rx_avail, 0);
      chk("midrst_data_after", rx_data, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_core.md
# uart_core

8N1 asynchronous serial transceiver with a byte-wide parallel handshake. It connects an on-chip bus peripheral, or a testbench partner, to a pair of RS-232-level-agnostic TX/RX pins. One free-running 16x-oversampling tick drives the receiver. The transmitter uses an exact per-bit counter. Full duplex: RX and TX operate independently.

## Interface
Parameters:
- freq_hz, 50000000, input clock frequency in Hz
- baud, 115200, line rate; DIV = freq_hz/(baud*16), integer truncated, minimum 1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (low = in reset)
- uart_rxd  in  1  serial input, idle high, asynchronous to clk
- uart_txd  out  1  serial output, idle high
- rx_data  out  8  last received byte
- rx_avail  out  1  received byte pending
- rx_error  out  1  framing error pending
- rx_ack  in  1  consumer acknowledge; clears rx_avail and rx_error
- tx_data  in  8  byte to send
- tx_wr  in  1  send strobe, single-cycle
- tx_busy  out  1  transmitter occupied

## Operation
- Reset values:
  - uart_txd=1, tx_busy=0
  - rx_data=0, rx_avail=0, rx_error=0
  - all counters 0, both FSMs IDLE
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - tx_wr=1 while tx_busy=0 latches tx_data.
  - tx_wr while tx_busy=1 is ignored; the latched byte is unaffected.
- RX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - uart_rxd passes through a 2-flop synchronizer.
  - A low level in IDLE starts START.
  - At 8 ticks the line is re-sampled. If it is high, the event is a glitch and the FSM returns to IDLE.
  - Each data bit and the stop bit are sampled 16 ticks after the previous sample, i.e. mid-bit.
- Stop sampled high:
  - rx_data <= shift register, rx_avail <= 1.
- Stop sampled low:
  - rx_error <= 1; rx_data and rx_avail are unchanged.
  - The FSM waits for the line to return high before re-arming IDLE.
- rx_ack=1 clears rx_avail and rx_error on the next edge.
  - If a new completion and rx_ack land in the same cycle, the completion wins and the flag stays set.
- Overrun: a new byte arriving while rx_avail=1 overwrites rx_data; rx_avail stays 1. No overrun flag.

## Timing
- Tick: a 1-cycle strobe every DIV cycles, free-running from reset, used by RX only.
- TX cycle timing:
  - tx_wr sampled at edge N. From edge N+1: tx_busy=1 and uart_txd=0.
  - Each bit lasts exactly 16*DIV cycles.
  - tx_busy falls exactly 10*16*DIV cycles after it rose, at the end of the stop bit.
  - A new tx_wr is accepted in that same cycle, allowing back-to-back frames.
- RX latency: rx_avail rises about 9.5 bit times plus 2-3 synchronizer/tick cycles after the start-bit falling edge. Mid-bit sampling error is within ±1 tick.
- Reset asserted mid-frame:
  - Immediately forces all reset values.
  - The frame is abandoned; no partial byte is delivered.

## Configuration
- UART_FRAMING_CHECK_EN defined (default build):
  - Stop bit checked as above; rx_error operational.
- UART_FRAMING_CHECK_EN undefined:
  - The stop bit is still sampled, but the byte is always delivered with rx_avail=1.
  - rx_error is tied to 0.
  - The stop-low wait state is omitted.

## Structure
- Package uart_pkg holds:
  - DATA_BITS=8 and OVERSAMPLE=16 constants
  - TX state enum {IDLE, START, DATA, STOP}
  - RX state enum, which adds WAIT_HIGH when the framing check is compiled in
- One sub-module, uart_baud_gen:
  - Parameter DIV; outputs the 1-cycle tick.
  - Instantiated once for RX.
  - TX keeps its own 16*DIV bit counter, restarted on accept.

## Test plan
- Reset: hold reset=0 for 4 cycles -> uart_txd=1, tx_busy=0, rx_avail=0, rx_error=0, rx_data=8'h00.
- TX frame (50 MHz, 115200 baud; DIV=27, bit=432 cycles): pulse tx_wr with 8'hA5.
  - uart_txd sampled mid-bit reads 0,1,0,1,0,0,1,0,1,1.
  - tx_busy is high for exactly 4320 cycles.
  - A second tx_wr 100 cycles in is ignored.
- Loopback: drive uart_rxd from uart_txd and send 8'h3C -> rx_avail=1 with rx_data=8'h3C.
  - After rx_ack=1 for one cycle, rx_avail=0 on the next edge.
- Framing error: drive an 8'h55 frame with the stop bit low.
  - With the macro: rx_error=1, rx_avail=0, rx_data unchanged.
  - Without the macro: rx_avail=1 with rx_data=8'h55, rx_error=0.
- Glitch: 200-cycle low pulse on uart_rxd -> no rx_avail; the next valid 8'h81 frame is received correctly.
- Overrun: send 8'h11 then 8'h22 without ack -> rx_data=8'h22, rx_avail=1. Reset mid-frame -> rx_avail=0, uart_txd=1.
